ul_div30_arb: RTL
=================

Name: ul_div30_arb

Overview:
- Round-robin arbiter and sequencer that shares a single divide/modulo-by-30 datapath among NUM_REQ requesters in the UL chain, e.g. slot/symbol index decomposition for several channel processors.
- Accepts one 15-bit unsigned operand per cycle from the granted requester.
- Registers quotient/remainder with the requester ID into a one-entry output stage with valid/ready backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of rsp_id; must satisfy 2^ID_W >= NUM_REQ.

Ports:
- clk  input  1  block clock.
- rst  input  1  asynchronous, active-high reset.
- req_vld  input  NUM_REQ  per-requester operand valid; must hold with stable operand until accepted.
- req_a  input  15*NUM_REQ  packed operands; requester i uses bits [15*i+14:15*i].
- req_rdy  output  NUM_REQ  one-hot accept strobe; at most one bit high per cycle.
- rsp_vld  output  1  result valid.
- rsp_rdy  input  1  downstream accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_d  output  11  floor(A/30).
- rsp_m  output  5  A mod 30.
- busy  output  1  rsp_vld OR any req_vld.

Behaviour:
- Reset (async assert, synchronous release) drives rsp_vld=0, rsp_id=0, rsp_d=0, rsp_m=0, rr_ptr=0. req_rdy is combinational and becomes 0 with rsp_vld=0 only if no req_vld is set.
- Output slot is free when rsp_vld=0 or (rsp_vld & rsp_rdy) = 1.
- Grant rule (combinational): when slot free, grant the lowest index g, searched circularly from rr_ptr (rr_ptr, rr_ptr+1, ..., wrapping at NUM_REQ-1 -> 0), with req_vld[g]=1. req_rdy[g]=1; all other bits are 0.
- If slot is not free, or no req_vld is set, req_rdy is all-zero.
- Accept occurs on a cycle with req_vld[g] & req_rdy[g]. On that clock edge:
  - rsp_d and rsp_m are loaded from the divider output for operand req_a[g].
  - rsp_id is loaded with g and rsp_vld is set to 1.
  - rr_ptr is loaded with (g+1) mod NUM_REQ.
- Latency: operand accepted in cycle t, result valid in cycle t+1. Throughput is 1 result per cycle while rsp_rdy=1.
- Consume without new accept: (rsp_vld & rsp_rdy) with no grant clears rsp_vld. Data registers hold their last values.
- Simultaneous consume and accept: rsp_vld stays 1 and the registers load the new result. No bubble.
- Backpressure (rsp_vld=1, rsp_rdy=0): rsp_d/rsp_m/rsp_id hold stable, no grant is issued, and rr_ptr holds.
- Arithmetic:
  - The full 15-bit range is legal. Max A=32767 gives D=1092 and M=7.
  - rsp_m is always in 0..29.
  - The divider is purely combinational between the grant mux and the output register; no multicycle path.
- Requester dropping req_vld before acceptance: no grant to it, and there is no error condition.
- Reset mid-transfer: a pending rsp_vld is discarded immediately, and rr_ptr returns to 0. Requesters must re-present their operands.
- Fairness: a continuously requesting requester is granted within NUM_REQ accepts.

Decomposition:
- Shared UL package holds constants DIV30_A_W=15, DIV30_Q_W=11, DIV30_R_W=5, DIV30_DIVISOR=30.
- One sub-module: the existing combinational divider ul_div_mod30 (A in, D/M out), instantiated once after the grant mux.
- Round-robin pointer and grant logic stay inline; no separate arbiter module.

Test Plan:
- Single requester 0 presents A=32767 with rsp_rdy=1 -> req_rdy=0001 in the same cycle; next cycle rsp_vld=1, rsp_id=0, rsp_d=1092, rsp_m=7.
- Boundary operands through requester 2: A=0, 29, 30, 59, 60 -> (D,M) = (0,0), (0,29), (1,0), (1,29), (2,0) on consecutive cycles, back-to-back with no bubbles.
- All four requesters hold req_vld with A=i+100 and rsp_rdy=1 -> rsp_id sequence 0,1,2,3,0,1, and rsp_d/rsp_m equal 3/10, 3/11, 3/12, 3/13.
- Backpressure: rsp_rdy=0 for 5 cycles while requesters 1 and 3 request -> outputs frozen, req_rdy=0000; after rsp_rdy=1, grant goes to the requester after the last-served one per rr_ptr.
- Wrap: rr_ptr=3 with only requester 0 requesting -> requester 0 granted, rr_ptr becomes 1.
- Assert rst mid-stream with rsp_vld=1 -> rsp_vld=0 asynchronously; after release, first grant goes to the lowest requesting index from 0.

Source files
------------

// File: rtl/ul_div30_arb_pkg.sv
// Shared UL constants for the divide/modulo-by-30 datapath.
package ul_div30_arb_pkg;

   localparam int unsigned DIV30_A_W     = 15;
   localparam int unsigned DIV30_Q_W     = 11;
   localparam int unsigned DIV30_R_W     = 5;
   localparam int unsigned DIV30_DIVISOR = 30;

endpackage : ul_div30_arb_pkg

// File: rtl/ul_div30_arb_div.sv
// Combinational divide/modulo by 30 of an unsigned operand.
module ul_div_mod30
   import ul_div30_arb_pkg::*;
(
   input  logic [DIV30_A_W-1:0] a,
   output logic [DIV30_Q_W-1:0] d,
   output logic [DIV30_R_W-1:0] m
);

   // Constant divisor; 32767/30 = 1092 fits in 11 bits, remainder < 30 in 5 bits.
   always_comb begin
      d = DIV30_Q_W'(32'(a) / DIV30_DIVISOR);
      m = DIV30_R_W'(32'(a) % DIV30_DIVISOR);
   end

endmodule : ul_div_mod30

// File: rtl/ul_div30_arb.sv
// Round-robin arbiter sharing one divide/modulo-by-30 datapath among requesters.
module ul_div30_arb
   import ul_div30_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = 2
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_vld,
   input  logic [DIV30_A_W*NUM_REQ-1:0]   req_a,
   output logic [NUM_REQ-1:0]             req_rdy,
   output logic                           rsp_vld,
   input  logic                           rsp_rdy,
   output logic [ID_W-1:0]                rsp_id,
   output logic [DIV30_Q_W-1:0]           rsp_d,
   output logic [DIV30_R_W-1:0]           rsp_m,
   output logic                           busy
);

   localparam int unsigned SUM_W = ID_W + 1;

   logic [ID_W-1:0]        rr_ptr;
   logic                   slot_free;
   logic [2*NUM_REQ-1:0]   vld_dbl;
   logic [NUM_REQ-1:0]     vld_rot;
   logic                   found;
   logic [SUM_W-1:0]       off;
   logic [SUM_W-1:0]       sum;
   logic [ID_W-1:0]        gnt_idx;
   logic [SUM_W-1:0]       nxt_sum;
   logic [ID_W-1:0]        nxt_ptr;
   logic [DIV30_A_W-1:0]   sel_a;
   logic [DIV30_Q_W-1:0]   div_d;
   logic [DIV30_R_W-1:0]   div_m;

   assign slot_free = !rsp_vld || rsp_rdy;
   assign busy      = rsp_vld || (|req_vld);

   // Circular priority search starting at rr_ptr, done on a rotated request vector.
   always_comb begin
      found   = 1'b0;
      off     = '0;
      vld_dbl = {req_vld, req_vld};
      vld_rot = NUM_REQ'(vld_dbl >> rr_ptr);
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (vld_rot[k]) begin
            found = 1'b1;
            off   = SUM_W'(k);
         end
      end
      sum = SUM_W'(rr_ptr) + off;
      if (sum >= SUM_W'(NUM_REQ))
         sum = sum - SUM_W'(NUM_REQ);
      gnt_idx = ID_W'(sum);
      nxt_sum = SUM_W'(gnt_idx) + SUM_W'(1);
      if (nxt_sum >= SUM_W'(NUM_REQ))
         nxt_sum = '0;
      nxt_ptr = ID_W'(nxt_sum);
      req_rdy = (found && slot_free) ? (NUM_REQ'(1) << gnt_idx) : '0;
   end

   // One-hot AND-OR operand mux feeding the divider.
   always_comb begin
      sel_a = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_rdy[i])
            sel_a = sel_a | req_a[i*DIV30_A_W +: DIV30_A_W];
      end
   end

   ul_div_mod30 u_div (
      .a (sel_a),
      .d (div_d),
      .m (div_m)
   );

   // Output stage and round-robin pointer; a grant implies an accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_vld <= 1'b0;
         rsp_id  <= '0;
         rsp_d   <= '0;
         rsp_m   <= '0;
         rr_ptr  <= '0;
      end else if (|req_rdy) begin
         rsp_vld <= 1'b1;
         rsp_id  <= gnt_idx;
         rsp_d   <= div_d;
         rsp_m   <= div_m;
         rr_ptr  <= nxt_ptr;
      end else if (rsp_rdy) begin
         rsp_vld <= 1'b0;
      end
   end

endmodule : ul_div30_arb
